regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/dual-read regfile in the single-cycle core.
- Adds configurable width, depth, read- and write-port counts, and a hardwired-zero entry 0.
- Adds write-to-read bypass, a per-register busy scoreboard for multi-cycle/pipelined writeback, and a sequential post-reset clear FSM with a ready flag.
- Sits between decode (reads, issue) and writeback (writes) of the pipelined core.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of 2, >= 2. AW = log2(DEPTH).
- NUM_RD, 2, read ports, 1..4.
- NUM_WR, 1, write ports, 1..2.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_wr_en  in  NUM_WR  per-port write enable.
- i_wr_addr  in  NUM_WR*AW  write addresses; port p at bits [p*AW +: AW].
- i_wr_data  in  NUM_WR*XLEN  write data; port p at bits [p*XLEN +: XLEN].
- i_rs_addr  in  NUM_RD*AW  read addresses; packed the same way.
- o_rs_data  out  NUM_RD*XLEN  read data, combinational.
- o_rs_busy  out  NUM_RD  scoreboard busy flag for each read address.
- i_iss_en  in  1  issue: mark destination busy.
- i_iss_addr  in  AW  issue destination.
- o_ready  out  1  high once the clear sequence has completed.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - FSM enters INIT; clear counter = 1.
  - All busy bits = 0.
  - o_ready = 0.
  - Storage is not cleared in bulk.
- Reset held low for several cycles: FSM stays in INIT with counter = 1. Reset asserted mid-RUN or mid-INIT restarts the sequence.
- INIT state:
  - Each cycle writes 0 to entry[counter], then increments the counter.
  - At counter = DEPTH-1, writes that entry and moves to RUN next cycle.
  - o_ready rises in the cycle DEPTH-1 clocks after the first clock with i_rst_n=1.
- During INIT:
  - i_wr_en and i_iss_en are ignored.
  - o_rs_data = 0 and o_rs_busy = 0 on all ports.
- RUN state: o_ready = 1; stays in RUN until reset.
- Entry 0:
  - Always reads 0 and is never busy.
  - Writes and issues to address 0 are discarded.
- Write, RUN only:
  - On a clock edge with i_wr_en[p]=1, entry[i_wr_addr[p]] <= i_wr_data[p].
  - Busy bit for that address is cleared.
- Two write ports, same address, same cycle: higher port index wins for both data and bypass.
- Read, combinational, latency 0 from address to data:
  - addr == 0 -> 0.
  - BYPASS=1 and a same-cycle enabled write matches addr -> that write's data (highest matching port).
  - Otherwise the stored entry.
- o_rs_busy[k]:
  - Equals busy[addr].
  - Forced 0 when addr == 0.
  - Forced 0 when BYPASS=1 and a same-cycle write matches addr.
- Issue: i_iss_en=1 in RUN sets busy[i_iss_addr] at the clock edge, unless the address is 0.
- Same-cycle issue and write to the same address: set wins, so busy = 1 afterwards; data is still written.
- Widths and wrap-around:
  - Addresses are exactly AW bits, so no out-of-range access is possible.
  - Clear counter is AW bits and never wraps, because the FSM exits INIT at DEPTH-1.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed on write; clear writes parity 0.
  - Adds output o_par_err [NUM_RD]. Bit k = 1 when the stored parity mismatches the stored data for a non-zero address in RUN.
  - o_par_err is 0 for bypassed reads, during INIT, and for addr 0.
  - Adds input i_par_inj (1 bit). When high, a write stores inverted parity, for fault-injection tests.
- Undefined: no parity storage, no o_par_err, no i_par_inj; storage is exactly DEPTH x XLEN.

Test Plan:
- Release reset with defaults and read x5 during INIT -> o_ready=0 for 31 cycles then 1; o_rs_data=0 throughout; entries 1..31 read 0 after ready.
- In RUN, write x7=32'hDEADBEEF with port 0 reading x7 in the same cycle -> BYPASS=1: same-cycle data DEADBEEF; BYPASS=0: old value 0, then DEADBEEF next cycle.
- Write x0=32'hFFFFFFFF and issue x0 -> reading x0 gives 0 and busy 0.
- NUM_WR=2, both ports write x3 (port0=32'h1, port1=32'h2) -> x3=32'h2; bypassed read is 32'h2.
- Issue x9, then two cycles later write x9 while issuing x9 again -> busy 1 after the issue, still 1 after the write+reissue cycle; a later write alone gives busy 0.
- REGFILE_PARITY_EN: write x4=32'h1 with i_par_inj=1, then read x4 -> o_par_err=1; a rewrite without injection gives o_par_err=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: hardwired x0, write-to-read bypass, busy scoreboard, post-reset clear.
// Optional parity storage and injection when REGFILE_PARITY_EN is defined.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_WR-1:0]      i_wr_en,
    input  logic [NUM_WR*AW-1:0]   i_wr_addr,
    input  logic [NUM_WR*XLEN-1:0] i_wr_data,
    input  logic [NUM_RD*AW-1:0]   i_rs_addr,
    output logic [NUM_RD*XLEN-1:0] o_rs_data,
    output logic [NUM_RD-1:0]      o_rs_busy,
    input  logic                   i_iss_en,
    input  logic [AW-1:0]          i_iss_addr,
    output logic                   o_ready
`ifdef REGFILE_PARITY_EN
    ,
    output logic [NUM_RD-1:0]      o_par_err,
    input  logic                   i_par_inj
`endif
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic [AW-1:0]     w_cnt_nxt;
    logic [DEPTH-1:0]  r_busy;
    logic [XLEN-1:0]   r_mem [DEPTH];
`ifdef REGFILE_PARITY_EN
    logic [DEPTH-1:0]  r_par;
`endif
    logic              w_run;

    assign w_run   = (r_state == ST_RUN);
    assign o_ready = w_run;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = r_cnt;
                end
            end
            ST_RUN: w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= AW'(1);
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_run) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (i_wr_en[p] && i_wr_addr[p*AW +: AW] != '0)
                        r_busy[i_wr_addr[p*AW +: AW]] <= 1'b0;
                end
                // Issue is applied last so a same-cycle set beats the clear.
                if (i_iss_en && i_iss_addr != '0)
                    r_busy[i_iss_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (!w_run) begin
                r_mem[r_cnt] <= '0;
`ifdef REGFILE_PARITY_EN
                r_par[r_cnt] <= 1'b0;
`endif
            end else begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (i_wr_en[p] && i_wr_addr[p*AW +: AW] != '0) begin
                        r_mem[i_wr_addr[p*AW +: AW]] <= i_wr_data[p*XLEN +: XLEN];
`ifdef REGFILE_PARITY_EN
                        r_par[i_wr_addr[p*AW +: AW]] <=
                            (^i_wr_data[p*XLEN +: XLEN]) ^ i_par_inj;
`endif
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_hit;
        logic [XLEN-1:0] w_byp;
        logic            w_zero;

        assign w_ra   = i_rs_addr[k*AW +: AW];
        assign w_zero = !w_run || (w_ra == '0);

        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (i_wr_en[p] && i_wr_addr[p*AW +: AW] == w_ra) begin
                        w_hit = 1'b1;
                        w_byp = i_wr_data[p*XLEN +: XLEN];
                    end
                end
            end
        end

        assign o_rs_data[k*XLEN +: XLEN] = w_zero ? '0 :
                                           w_hit  ? w_byp : r_mem[w_ra];
        assign o_rs_busy[k] = !w_zero && !w_hit && r_busy[w_ra];
`ifdef REGFILE_PARITY_EN
        assign o_par_err[k] = !w_zero && !w_hit &&
                              (r_par[w_ra] != (^r_mem[w_ra]));
`endif
    end

endmodule
